// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit_pkg
// Brief   : Shared widths, constants and buffer entry type for the
//           instruction fetch stage.
// Revision: 1.0 - initial release
// ============================================================================
package if_fetch_unit_pkg;

  localparam int c_xlen = 32;

  // addi x0,x0,0 : shown to decode whenever no instruction is valid
  localparam logic [c_xlen-1:0] c_nop_inst = 32'h0000_0013;
  localparam logic [c_xlen-1:0] c_reset_pc = 32'h0000_0000;

  typedef logic [c_xlen-1:0] addr_t;
  typedef logic [c_xlen-1:0] inst_t;

  // One buffered fetch: the word and the PC it was read from
  typedef struct packed {
    addr_t pc;
    inst_t inst;
  } fetch_entry_t;

  localparam int c_entry_w = $bits(fetch_entry_t);

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_inst_fifo.sv
`default_nettype none
// ============================================================================
// Module  : if_inst_fifo
// Brief   : Synchronous FIFO holding fetched {pc, inst} entries, with a
//           flush input and an occupancy count for credit accounting.
// Revision: 1.0 - initial release
// ============================================================================
module if_inst_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Pointer and occupancy bookkeeping; flush empties the buffer outright
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage array; contents need no reset because the count gates validity
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : if_fetch_unit
// Brief   : Instruction fetch stage. Owns the PC, issues one ROM read per
//           cycle under credit control, buffers {pc, inst} and hands them to
//           decode over valid/ready. Redirects flush the buffer and bump an
//           epoch so stale ROM responses are discarded.
// Options : FETCH_PERF_CNT_EN - adds fetch/flush/stall performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = c_reset_pc,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = c_nop_inst
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_inst_o,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [31:0] perf_stall_cnt_o,
`endif
  output logic [31:0] id_pc_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] c_depth = (CW+1)'(FIFO_DEPTH);
  localparam logic [31:0] c_pc_init = {RESET_PC[31:2], 2'b00};

  logic [31:0]   r_pc;
  logic          r_inflight;
  logic          r_epoch;
  logic          r_req_epoch;
  logic [31:0]   r_req_addr;

  logic [CW-1:0] w_count;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic [CW:0]   w_credit;
  logic          w_unused_ok;

  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid & id_ready_i;

  // Slots committed after this cycle: buffered + in flight, minus the one
  // decode takes now. Counting the pop lets a full buffer keep streaming.
  assign w_credit = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

  // rst is folded in so the strobe drops the moment reset asserts
  assign w_issue = rst & ~hold_i & ~jump_en_i & (w_credit < c_depth);

  // A response is kept only if no redirect happened since it was issued;
  // a redirect in the response cycle itself also drops it
  assign w_push = r_inflight & (r_req_epoch == r_epoch) & ~jump_en_i;

  assign w_push_entry.pc   = r_req_addr;
  assign w_push_entry.inst = rom_data_i;

  // Low target bits are discarded by word alignment
  assign w_unused_ok = ^jump_addr_i[1:0];

  if_inst_fifo #(
    .WIDTH (c_entry_w),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (jump_en_i),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  // PC, epoch and in-flight request tracking; redirect takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= c_pc_init;
      r_inflight  <= 1'b0;
      r_epoch     <= 1'b0;
      r_req_epoch <= 1'b0;
      r_req_addr  <= '0;
    end else begin
      r_inflight <= w_issue;
      if (jump_en_i) begin
        r_epoch <= ~r_epoch;
        r_pc    <= {jump_addr_i[31:2], 2'b00};
      end else if (w_issue) begin
        r_pc        <= r_pc + 32'd4;
        r_req_epoch <= r_epoch;
        r_req_addr  <= r_pc;
      end
    end
  end

  assign rom_req_o  = w_issue;
  assign rom_addr_o = r_pc;
  assign id_valid_o = w_valid;
  assign id_inst_o  = w_valid ? w_head.inst : NOP_INST;
  assign id_pc_o    = w_valid ? w_head.pc   : 32'h0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_flush;
  logic [31:0] r_perf_stall;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch <= '0;
      r_perf_flush <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_push)               r_perf_fetch <= r_perf_fetch + 32'd1;
      if (jump_en_i)            r_perf_flush <= r_perf_flush + 32'd1;
      if (!w_valid && !hold_i)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = r_perf_fetch;
  assign perf_flush_cnt_o = r_perf_flush;
  assign perf_stall_cnt_o = r_perf_stall;
`else
  // Performance counters are not built in this configuration
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_fetch_unit
// Brief   : Self-checking bench for if_fetch_unit: directed cycle-exact
//           scenarios followed by a randomized run against a stream model
//           (program-order PCs, redirect targets, ROM contents).
// Options : FETCH_PERF_CNT_EN - also checks the performance counters.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        jump;
    logic [31:0] jaddr;
    logic        hold;
    logic        valid;
    logic        ready;
    logic [31:0] inst;
    logic [31:0] pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] pf_fetch;
    logic [31:0] pf_flush;
    logic [31:0] pf_stall;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .rom_req_o   (rom_req),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .jump_en_i   (jump),
        .jump_addr_i (jaddr),
        .hold_i      (hold),
        .id_valid_o  (valid),
        .id_ready_i  (ready),
        .id_inst_o   (inst),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt_o (pf_fetch),
        .perf_flush_cnt_o (pf_flush),
        .perf_stall_cnt_o (pf_stall),
`endif
        .id_pc_o     (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        case (a)
            32'h0:   rom_fn = 32'h0010_0093;
            32'h4:   rom_fn = 32'h0020_0113;
            32'h8:   rom_fn = 32'h0020_81B3;
            default: rom_fn = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        endcase
    endfunction

    // ROM: fixed one-cycle read latency
    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_inst;
        logic        prev_stall;
        int          hs;
        int          flushes;
        int          stalls;

        rst = 1'b0; ready = 1'b1; hold = 1'b0; jump = 1'b0; jaddr = '0;

        // ---------------- reset values ----------------
        repeat (3) cyc();
        #1;
        chk("rst_req",   rom_req,  1'b0);
        chk("rst_addr",  rom_addr, 32'h0);
        chk("rst_valid", valid,    1'b0);
        chk("rst_inst",  inst,     NOP);
        chk("rst_pc",    pc,       32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_pf_fetch", pf_fetch, 32'h0);
        chk("rst_pf_flush", pf_flush, 32'h0);
        chk("rst_pf_stall", pf_stall, 32'h0);
`endif

        // ---------------- streaming after release ----------------
        cyc(); rst = 1'b1; #1;
        chk("s_req0",  rom_req,  1'b1);
        chk("s_addr0", rom_addr, 32'h0);
        cyc(); #1;
        chk("s_addr1", rom_addr, 32'h4);
        cyc(); #1;
        chk("s_addr2", rom_addr, 32'h8);
        chk("s_val2",  valid,    1'b1);
        chk("s_pc2",   pc,       32'h0);
        chk("s_inst2", inst,     32'h0010_0093);
        cyc(); #1;
        chk("s_val3",  valid,    1'b1);
        chk("s_pc3",   pc,       32'h4);
        chk("s_inst3", inst,     32'h0020_0113);
        cyc(); #1;
        chk("s_val4",  valid,    1'b1);
        chk("s_pc4",   pc,       32'h8);
        chk("s_inst4", inst,     32'h0020_81B3);
        cyc();

        // ---------------- redirect: head 0x10, 0x14 in flight ----------------
        cyc(); jump = 1'b1; jaddr = 32'h0000_0103; #1;
        chk("j_head", pc,      32'h10);
        chk("j_req",  rom_req, 1'b0);
        cyc(); jump = 1'b0; jaddr = '0; #1;
        chk("j_val1",  valid,    1'b0);
        chk("j_req1",  rom_req,  1'b1);
        chk("j_addr1", rom_addr, 32'h100);
        cyc(); #1;
        chk("j_val2", valid, 1'b0);
        cyc(); #1;
        chk("j_val3",  valid, 1'b1);
        chk("j_pc3",   pc,    32'h100);
        chk("j_inst3", inst,  rom_fn(32'h100));
        cyc(); #1;
        chk("j_pc4", pc, 32'h104);

        // ---------------- hold for 5 cycles ----------------
        cyc(); hold = 1'b1; #1;
        chk("h_pc11",  pc,      32'h108);
        chk("h_req11", rom_req, 1'b0);
        cyc(); #1;
        chk("h_val12", valid,    1'b1);
        chk("h_pc12",  pc,       32'h10C);
        chk("h_req12", rom_req,  1'b0);
        chk("h_adr12", rom_addr, 32'h110);
        for (int k = 13; k <= 15; k++) begin
            cyc(); #1;
            chk("h_val_drained", valid,    1'b0);
            chk("h_req_held",    rom_req,  1'b0);
            chk("h_addr_frozen", rom_addr, 32'h110);
        end
        cyc(); hold = 1'b0; #1;
        chk("h_req16", rom_req,  1'b1);
        chk("h_adr16", rom_addr, 32'h110);
        cyc(); #1;
        chk("h_adr17", rom_addr, 32'h114);
        cyc(); #1;
        chk("h_val18", valid, 1'b1);
        chk("h_pc18",  pc,    32'h110);

        // ---------------- decode not ready from release ----------------
        cyc(); rst = 1'b0; ready = 1'b0; #1;
        cyc(); rst = 1'b1; #1;
        chk("f_req0",  rom_req,  1'b1);
        chk("f_addr0", rom_addr, 32'h0);
        cyc(); #1;
        chk("f_req1",  rom_req,  1'b1);
        chk("f_addr1", rom_addr, 32'h4);
        for (int k = 2; k <= 5; k++) begin
            cyc(); #1;
            chk("f_req_stop", rom_req, 1'b0);
            chk("f_pc_head",  pc,      32'h0);
            chk("f_val",      valid,   1'b1);
        end
        cyc(); ready = 1'b1; #1;
        chk("f_req6",  rom_req,  1'b1);
        chk("f_addr6", rom_addr, 32'h8);
        chk("f_pc6",   pc,       32'h0);
        for (int k = 1; k <= 5; k++) begin
            cyc(); #1;
            chk("f_stream_val", valid, 1'b1);
            chk("f_stream_pc",  pc,    32'(4 * k));
        end

        // ---------------- asynchronous reset with full buffer ----------------
        cyc(); ready = 1'b0;
        repeat (3) cyc();
        #1;
        chk("ar_full_val", valid, 1'b1);
        rst = 1'b0;
        #1;
        chk("ar_req",   rom_req,  1'b0);
        chk("ar_addr",  rom_addr, 32'h0);
        chk("ar_valid", valid,    1'b0);
        chk("ar_inst",  inst,     NOP);
        chk("ar_pc",    pc,       32'h0);
        cyc();
        cyc(); rst = 1'b1; ready = 1'b1; #1;
        chk("ar_req0",  rom_req,  1'b1);
        chk("ar_addr0", rom_addr, 32'h0);
        cyc();
        cyc(); #1;
        chk("ar_val2", valid, 1'b1);
        chk("ar_pc2",  pc,    32'h0);

        // ---------------- randomized run against stream model ----------------
        cyc(); rst = 1'b0; hold = 1'b0; jump = 1'b0; #1;
        cyc(); rst = 1'b1; #1;
        exp_pc     = 32'h0;
        prev_stall = 1'b0;
        prev_pc    = '0;
        prev_inst  = '0;
        hs         = 0;
        flushes    = 0;
        stalls     = 1;
        for (int i = 0; i < 800; i++) begin
            cyc();
            ready = (($urandom % 4) != 0);
            hold  = (($urandom % 8) == 0);
            jump  = (($urandom % 24) == 0);
            jaddr = $urandom;
            #1;
            if (prev_stall) begin
                chk("r_stable_val",  valid, 1'b1);
                chk("r_stable_pc",   pc,    prev_pc);
                chk("r_stable_inst", inst,  prev_inst);
            end
            if (hold) chk("r_hold_noreq", rom_req, 1'b0);
            if (rom_req) chk("r_addr_align", rom_addr & 32'h3, 32'h0);
            if (valid) begin
                if (ready) begin
                    chk("r_pc",   pc,   exp_pc);
                    chk("r_inst", inst, rom_fn(exp_pc));
                    exp_pc = exp_pc + 32'd4;
                    hs++;
                end
            end else begin
                chk("r_nop", inst, NOP);
            end
            prev_stall = valid & ~ready & ~jump;
            prev_pc    = pc;
            prev_inst  = inst;
            if (jump) begin
                exp_pc = {jaddr[31:2], 2'b00};
                flushes++;
            end
            if (!valid && !hold) stalls++;
        end
        cyc(); jump = 1'b0; hold = 1'b1; #1;
        chk("r_progress", (hs > 100), 1'b1);
`ifdef FETCH_PERF_CNT_EN
        chk("pf_flush", pf_flush, 32'(flushes));
        chk("pf_stall", pf_stall, 32'(stalls));
        chk("pf_fetch_ge", (pf_fetch >= 32'(hs)), 1'b1);
        rst = 1'b0;
        #1;
        chk("pf_clr_fetch", pf_fetch, 32'h0);
        chk("pf_clr_flush", pf_flush, 32'h0);
        chk("pf_clr_stall", pf_stall, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
